dcu_sc_miss_resp: RTL and testbench

- Responder end of the stack-cache read-miss request issued by the IU pipe (sc_dcache_req / iu_data_vld / sc_data_vld).
- Sits in the DCU. Latches the missing word address, looks it up in the data cache, and on a D$ miss fetches the word over the BIU.
- Returns the word to the IU with a one-cycle valid pulse. Handles trap kill and a BIU watchdog.

---
 rtl/dcu_sc_miss_resp.sv | 122 ++++++++++++
 tb/tb_dcu_sc_miss_resp.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dcu_sc_miss_resp.sv
// Stack-cache read-miss responder: looks the missing word up in the D$ and,
// on a D$ miss, fetches it over the BIU before returning it to the IU.
module dcu_sc_miss_resp #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        sc_dcache_req,
  input  logic [29:0] sc_addr,
  input  logic        sc_kill,
  input  logic        norm_busy,
  output logic        dc_lookup,
  output logic [29:0] dc_addr,
  input  logic        dc_tag_hit,
  input  logic [31:0] dc_rdata,
  output logic        biu_req,
  output logic [29:0] biu_addr,
  input  logic        biu_ack,
  input  logic [31:0] biu_data,
  output logic [31:0] iu_data,
  output logic        iu_data_vld,
  output logic        sc_data_vld,
  output logic        dcu_sc_busy,
  output logic        dcu_sc_err
);

  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, FILL, DRAIN, RESP, GAP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state, state_nxt;
  logic [29:0] addr_q, addr_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic [31:0] data_q, data_nxt;
  logic        err_q, err_nxt;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= IDLE;
      addr_q   <= '0;
      wait_cnt <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      addr_q   <= addr_nxt;
      wait_cnt <= wait_cnt_nxt;
      data_q   <= data_nxt;
      err_q    <= err_nxt;
    end
  end

  // An in-flight BIU read cannot be cancelled, so a kill during FILL moves to
  // DRAIN to swallow the ack; a kill coinciding with the ack just discards it.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    wait_cnt_nxt = wait_cnt;
    data_nxt     = data_q;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (sc_dcache_req && !norm_busy && !sc_kill) begin
          addr_nxt  = sc_addr;
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: state_nxt = sc_kill ? IDLE : CHECK;
      CHECK: begin
        if (sc_kill) begin
          state_nxt = IDLE;
        end else if (dc_tag_hit) begin
          data_nxt  = dc_rdata;
          state_nxt = RESP;
        end else begin
          wait_cnt_nxt = '0;
          state_nxt    = FILL;
        end
      end
      FILL: begin
        if (biu_ack) begin
          if (sc_kill) begin
            state_nxt = IDLE;
          end else begin
            data_nxt  = biu_data;
            state_nxt = RESP;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
          state_nxt    = sc_kill ? DRAIN : FILL;
        end
      end
      DRAIN: begin
        if (biu_ack) begin
          state_nxt = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      RESP:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign dc_lookup   = (state == LOOKUP);
  assign dc_addr     = addr_q;
  assign biu_req     = (state == FILL) || (state == DRAIN);
  assign biu_addr    = addr_q;
  assign iu_data     = data_q;
  assign iu_data_vld = (state == RESP);
  assign sc_data_vld = (state == RESP);
  assign dcu_sc_busy = (state != IDLE);
  assign dcu_sc_err  = err_q;

endmodule

// File: tb/tb_dcu_sc_miss_resp.sv
// Self-checking bench for dcu_sc_miss_resp: directed scenarios plus random
// transactions scored against a transaction-level outcome model.
module tb_dcu_sc_miss_resp;

  localparam int MAX_WAIT = 8;

  logic        clk;
  logic        reset_l;
  logic        sc_dcache_req;
  logic [29:0] sc_addr;
  logic        sc_kill;
  logic        norm_busy;
  logic        dc_lookup;
  logic [29:0] dc_addr;
  logic        dc_tag_hit;
  logic [31:0] dc_rdata;
  logic        biu_req;
  logic [29:0] biu_addr;
  logic        biu_ack;
  logic [31:0] biu_data;
  logic [31:0] iu_data;
  logic        iu_data_vld;
  logic        sc_data_vld;
  logic        dcu_sc_busy;
  logic        dcu_sc_err;

  int          total = 0;
  int          bad = 0;
  logic [31:0] last_data = '0;

  dcu_sc_miss_resp #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_l(reset_l),
    .sc_dcache_req(sc_dcache_req), .sc_addr(sc_addr), .sc_kill(sc_kill),
    .norm_busy(norm_busy), .dc_lookup(dc_lookup), .dc_addr(dc_addr),
    .dc_tag_hit(dc_tag_hit), .dc_rdata(dc_rdata), .biu_req(biu_req),
    .biu_addr(biu_addr), .biu_ack(biu_ack), .biu_data(biu_data),
    .iu_data(iu_data), .iu_data_vld(iu_data_vld), .sc_data_vld(sc_data_vld),
    .dcu_sc_busy(dcu_sc_busy), .dcu_sc_err(dcu_sc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request from acceptance to idle. Expected outcome comes from the
  // transaction rules: hit after 3 cycles, miss after 3+ack cycles, watchdog
  // after MAX_WAIT unacked BIU cycles, kill before the response drops it.
  task automatic applyStimulus(input string tag, input logic [29:0] addr, input logic hit,
                               input logic [31:0] rdata, input logic [31:0] bdata,
                               input int ack_at, input int kill_rel, input int nb);
    int cyc = 0, req_n = 0, lookup_n = 0, lookup_at = 0, vld_n = 0, vld_at = 0;
    int err_n = 0, sync_bad = 0, kill_cyc, kf;
    int e_vld = 0, e_lat = 0, e_req = 0, e_err = 0;
    logic [29:0] dc_seen = '0, biu_seen = '0;
    logic [31:0] got = '0, e_data;
    bit done = 0;

    kill_cyc = (kill_rel > 0) ? nb + kill_rel : -1;
    e_data = last_data;
    if (kill_rel == 1 || kill_rel == 2) begin
      e_vld = 0;
    end else if (hit) begin
      e_vld = 1; e_lat = nb + 3; e_data = rdata;
    end else begin
      kf = (kill_rel >= 3) ? kill_rel - 2 : 0;
      if (ack_at >= 1 && ack_at <= MAX_WAIT) begin
        e_req = ack_at;
        if (kf == 0 || kf > ack_at) begin
          e_vld = 1; e_lat = nb + 3 + ack_at; e_data = bdata;
        end
      end else begin
        e_req = MAX_WAIT; e_err = 1;
      end
    end

    sc_addr = addr; dc_tag_hit = hit; dc_rdata = rdata; biu_data = bdata;
    biu_ack = 1'b0; sc_kill = 1'b0; norm_busy = (nb > 0); sc_dcache_req = 1'b1;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
      if (dc_lookup) begin lookup_n++; lookup_at = cyc; dc_seen = dc_addr; end
      if (biu_req) begin req_n++; biu_seen = biu_addr; end
      if (iu_data_vld) begin vld_n++; vld_at = cyc; got = iu_data; sc_dcache_req = 1'b0; end
      if (sc_data_vld !== iu_data_vld) sync_bad++;
      if (dcu_sc_err) begin err_n++; sc_dcache_req = 1'b0; end
      biu_ack = biu_req && (req_n == ack_at);
      sc_kill = (cyc == kill_cyc);
      if (sc_kill) sc_dcache_req = 1'b0;
      norm_busy = (cyc < nb) ? 1'b1 : ((cyc > nb) ? 1'($urandom) : 1'b0);
      if (cyc > nb) sc_addr = 30'($urandom);
      if (cyc > nb && !dcu_sc_busy) done = 1;
    end
    sc_dcache_req = 1'b0; sc_kill = 1'b0; biu_ack = 1'b0; norm_busy = 1'b0;

    checkOutput({tag, ".done"}, 64'(done), 64'd1);
    checkOutput({tag, ".lookup_n"}, 64'(lookup_n), 64'd1);
    checkOutput({tag, ".lookup_at"}, 64'(lookup_at), 64'(nb + 1));
    checkOutput({tag, ".dc_addr"}, 64'(dc_seen), 64'(addr));
    checkOutput({tag, ".vld_n"}, 64'(vld_n), 64'(e_vld));
    if (e_vld != 0) begin
      checkOutput({tag, ".latency"}, 64'(vld_at), 64'(e_lat));
      checkOutput({tag, ".data"}, 64'(got), 64'(e_data));
    end
    checkOutput({tag, ".biu_cycles"}, 64'(req_n), 64'(e_req));
    if (e_req > 0) checkOutput({tag, ".biu_addr"}, 64'(biu_seen), 64'(addr));
    checkOutput({tag, ".err_n"}, 64'(err_n), 64'(e_err));
    checkOutput({tag, ".sc_vld_sync"}, 64'(sync_bad), 64'd0);
    checkOutput({tag, ".iu_data_hold"}, 64'(iu_data), 64'(e_data));
    last_data = e_data;
  endtask

  initial begin
    sc_dcache_req = 1'b0; sc_addr = '0; sc_kill = 1'b0; norm_busy = 1'b0;
    dc_tag_hit = 1'b0; dc_rdata = '0; biu_ack = 1'b0; biu_data = '0;
    reset_l = 1'b1;
    #2 reset_l = 1'b0;
    #1;
    checkOutput("rst.busy", 64'(dcu_sc_busy), 64'd0);
    checkOutput("rst.outs", 64'({dc_lookup, biu_req, iu_data_vld, sc_data_vld, dcu_sc_err}), 64'd0);
    checkOutput("rst.data", 64'(iu_data), 64'd0);
    checkOutput("rst.addr", 64'({dc_addr, biu_addr}), 64'd0);
    #20 reset_l = 1'b1;
    tick();

    applyStimulus("hit", 30'h0000_1F04, 1'b1, 32'hCAFE_F00D, 32'h0, 0, 0, 0);
    applyStimulus("miss", 30'h0ABC_0010, 1'b0, 32'hDEAD_0000, 32'h1234_5678, 5, 0, 0);
    applyStimulus("arb", 30'h0000_2222, 1'b1, 32'h5555_AAAA, 32'h0, 0, 0, 4);
    applyStimulus("kill_fill", 30'h0000_0333, 1'b0, 32'h0, 32'hBAD0_BAD0, 5, 4, 0);
    applyStimulus("after_kill", 30'h0000_0444, 1'b1, 32'h0BAD_F00D, 32'h0, 0, 0, 0);
    applyStimulus("kill_lookup", 30'h0000_0555, 1'b1, 32'h1111_1111, 32'h0, 0, 1, 0);
    applyStimulus("kill_check", 30'h0000_0666, 1'b1, 32'h2222_2222, 32'h0, 0, 2, 0);
    applyStimulus("watchdog", 30'h0000_0777, 1'b0, 32'h0, 32'h3333_3333, 0, 0, 0);
    applyStimulus("ack_last", 30'h0000_0888, 1'b0, 32'h0, 32'h4444_4444, MAX_WAIT, 0, 0);
    applyStimulus("kill_ack", 30'h0000_0999, 1'b0, 32'h0, 32'h6666_6666, 3, 5, 0);

    // Asynchronous reset in the middle of a BIU fill
    sc_addr = 30'h0000_0ABC; dc_tag_hit = 1'b0; sc_dcache_req = 1'b1;
    tick(); tick(); tick(); tick();
    checkOutput("rst_fill.pre_req", 64'(biu_req), 64'd1);
    #2 reset_l = 1'b0;
    #1;
    checkOutput("rst_fill.busy", 64'(dcu_sc_busy), 64'd0);
    checkOutput("rst_fill.outs", 64'({dc_lookup, biu_req, iu_data_vld, sc_data_vld, dcu_sc_err}), 64'd0);
    checkOutput("rst_fill.data", 64'(iu_data), 64'd0);
    checkOutput("rst_fill.addr", 64'({dc_addr, biu_addr}), 64'd0);
    sc_dcache_req = 1'b0;
    last_data = '0;
    #14 reset_l = 1'b1;
    tick();
    applyStimulus("post_rst", 30'h0000_0DEF, 1'b1, 32'h7777_8888, 32'h0, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      int ack_at, kill_rel;
      ack_at = int'($urandom_range(1, 10));
      kill_rel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
      applyStimulus("rnd", 30'($urandom), 1'($urandom), $urandom, $urandom,
                    ack_at, kill_rel, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
